seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Iterative signed divider, the inverse of the pipelined Booth multiplier: 2N-bit dividend / N-bit divisor -> N-bit quotient and N-bit remainder.
- Restoring algorithm on magnitudes, one quotient bit per clock, then a sign-fixup stage.
- Sits beside the multiplier in the arithmetic datapath. Input and output use valid/ready handshakes.

Parameters:
- N, 16, divisor/quotient/remainder width; dividend is 2N bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle, can accept operands
- dividend  in  2N  signed dividend
- divisor  in  N  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  N  signed quotient
- remainder  out  N  signed remainder
- div_by_zero  out  1  divisor was 0
- overflow  out  1  quotient not representable in N signed bits
- busy  out  1  operation in progress (not IDLE)

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - quotient, remainder, div_by_zero and overflow all 0.
  - Reset mid-operation abandons the operation with no output.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - in_valid=1 at an edge latches operands and goes to PREP. in_valid is ignored in all other states (in_ready=0).
- PREP (1 cycle):
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Latch |dividend| (2N-bit unsigned; -2^(2N-1) maps to 2^(2N-1)) and |divisor| (N-bit unsigned).
  - dz = (divisor==0).
  - pre_ovf = (upper N bits of |dividend| >= |divisor|) and not dz.
  - Clear the iteration counter.
- ITER (exactly N cycles, counter 0..N-1):
  - Each step: shift the {partial remainder, dividend} pair left by 1.
  - Trial subtract |divisor| from the (N+1)-bit partial remainder.
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Leave after count N-1.
- FIX (1 cycle):
  - If dz: div_by_zero=1, overflow=0, quotient=all ones, remainder=dividend[N-1:0].
  - Else if pre_ovf, or (sign_q=0 and mag_q > 2^(N-1)-1), or (sign_q=1 and mag_q > 2^(N-1)):
    - overflow=1, remainder=0.
    - quotient = 2^(N-1)-1 if sign_q=0, else -2^(N-1).
  - Else: quotient = sign_q ? -mag_q : mag_q; remainder = sign_r ? -mag_r : mag_r. Flags 0.
- DONE:
  - out_valid=1; outputs stable.
  - out_valid & out_ready at an edge -> IDLE, out_valid=0.
  - Outputs keep their last value in IDLE.
- Latency: fixed N+2 edges from the accepting edge to out_valid=1, identical for the dz and overflow cases (18 for N=16).
  - With out_ready held 1, the next operand is accepted no earlier than the edge after the DONE handshake.
- Arithmetic semantics:
  - Truncation toward zero; remainder takes the dividend's sign.
  - |remainder| < |divisor|.
  - dividend = quotient*divisor + remainder whenever overflow=0 and div_by_zero=0.
- busy=1 in PREP, ITER, FIX and DONE.

Decomposition:
- Shared package:
  - N default.
  - State enum (IDLE, PREP, ITER, FIX, DONE).
  - Constants QMAX=2^(N-1)-1, QMIN=-2^(N-1).
  - Shared with the multiplier's width constants.
- One sub-module, div_restore_step: combinational single restoring step.
  - Inputs: partial remainder (N+1), next dividend bit, |divisor|.
  - Outputs: new partial remainder, quotient bit.
- FSM, counter and sign logic live in the top.

Test Plan:
- 1000 / 7 -> after 18 cycles out_valid=1, quotient=142 (0x008E), remainder=6, flags 0.
- -1000 / 7 -> quotient=0xFF72 (-142), remainder=0xFFFA (-6); 1000 / -7 -> quotient=0xFF72, remainder=6.
- Boundaries:
  - -32768 / 1 -> quotient=0x8000, overflow=0.
  - 32768 / 1 -> overflow=1, quotient=0x7FFF, remainder=0.
  - 0x00010000 / 1 -> overflow=1 (pre_ovf), quotient=0x7FFF.
  - 0x80000000 / -1 -> overflow=1, quotient=0x7FFF.
- 12345 / 0 -> div_by_zero=1, quotient=0xFFFF, remainder=0x3039, out_valid at cycle 18.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: outputs stable, in_ready=0, and new in_valid pulses are ignored.
  - Raise out_ready: one handshake, then IDLE with in_ready=1.
- Reset mid-operation:
  - Assert rst=0 at ITER count 5: next cycle state IDLE, out_valid=0, all outputs 0.
  - A following 100 / 3 -> quotient=33, remainder=1.

Source files
------------

// File: rtl/seq_signed_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_signed_divider_pkg
//  Description : Shared widths, FSM state encoding and saturation constants
//                for the iterative signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_signed_divider_pkg;

    localparam int N_DEFAULT = 16;
    // Kept equal to the Booth multiplier operand width so the two units pair up
    localparam int MUL_WIDTH = N_DEFAULT;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    localparam logic [N_DEFAULT-1:0] QMAX = {1'b0, {(N_DEFAULT-1){1'b1}}};
    localparam logic [N_DEFAULT-1:0] QMIN = {1'b1, {(N_DEFAULT-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/seq_signed_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_signed_divider_if
//  Description : Operand/result valid-ready bundle for the signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_signed_divider_if
    import seq_signed_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;
    logic           busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_signed_divider_restore_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restore_step
//  Description : One combinational restoring-division step on magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_restore_step
    import seq_signed_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  wire logic [N:0]   rem_in,
    input  wire logic         bit_in,
    input  wire logic [N-1:0] divisor_abs,
    output logic      [N:0]   rem_out,
    output logic              q_bit
);
    logic [N+1:0] w_shifted;
    logic [N:0]   w_diff;

    assign w_shifted = {rem_in, bit_in};
    assign q_bit     = (w_shifted >= {2'b00, divisor_abs});
    assign w_diff    = w_shifted[N:0] - {1'b0, divisor_abs};
    assign rem_out   = q_bit ? w_diff : w_shifted[N:0];
endmodule
`default_nettype wire

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_signed_divider
//  Description : 2N/N signed restoring divider, one quotient bit per clock,
//                with sign fix-up, saturation and divide-by-zero reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    seq_signed_divider_if.slave   bus
);
    localparam logic [2:0] c_IDLE = ST_IDLE;
    localparam logic [2:0] c_PREP = ST_PREP;
    localparam logic [2:0] c_ITER = ST_ITER;
    localparam logic [2:0] c_FIX  = ST_FIX;
    localparam logic [2:0] c_DONE = ST_DONE;

    localparam int           c_CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);
    localparam logic [N-1:0] c_QMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_QMIN = {1'b1, {(N-1){1'b0}}};

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2*N-1:0]  r_dvd;
    logic [N-1:0]    r_dvs;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_low;
    logic [N-1:0]    r_abs_dvs;
    logic            r_sign_q;
    logic            r_sign_r;
    logic            r_dz;
    logic            r_pre_ovf;
    logic [N-1:0]    r_quot;
    logic [N-1:0]    r_remd;
    logic            r_dz_out;
    logic            r_ovf_out;

    logic [2*N-1:0]  w_abs_dvd;
    logic [N-1:0]    w_abs_dvs;
    logic [N:0]      w_step_rem;
    logic            w_q_bit;
    logic            w_q_ovf;

    assign w_abs_dvd = r_dvd[2*N-1] ? -r_dvd : r_dvd;
    assign w_abs_dvs = r_dvs[N-1]   ? -r_dvs : r_dvs;

    // After ITER the shift register holds |q|; the negative range reaches one further
    assign w_q_ovf = r_sign_q ? (r_low[N-1] & (|r_low[N-2:0])) : r_low[N-1];

    div_restore_step #(.N(N)) u_step (
        .rem_in      (r_rem),
        .bit_in      (r_low[N-1]),
        .divisor_abs (r_abs_dvs),
        .rem_out     (w_step_rem),
        .q_bit       (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_low     <= '0;
            r_abs_dvs <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dz      <= 1'b0;
            r_pre_ovf <= 1'b0;
            r_quot    <= '0;
            r_remd    <= '0;
            r_dz_out  <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_dvd   <= bus.dividend;
                        r_dvs   <= bus.divisor;
                        r_state <= c_PREP;
                    end
                end
                c_PREP: begin
                    r_sign_q  <= r_dvd[2*N-1] ^ r_dvs[N-1];
                    r_sign_r  <= r_dvd[2*N-1];
                    r_abs_dvs <= w_abs_dvs;
                    r_rem     <= {1'b0, w_abs_dvd[2*N-1:N]};
                    r_low     <= w_abs_dvd[N-1:0];
                    r_dz      <= (r_dvs == '0);
                    // A high half >= divisor means |q| needs more than N bits
                    r_pre_ovf <= (w_abs_dvd[2*N-1:N] >= w_abs_dvs) && (r_dvs != '0);
                    r_cnt     <= '0;
                    r_state   <= c_ITER;
                end
                c_ITER: begin
                    r_rem <= w_step_rem;
                    r_low <= {r_low[N-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    if (r_dz) begin
                        r_dz_out  <= 1'b1;
                        r_ovf_out <= 1'b0;
                        r_quot    <= '1;
                        r_remd    <= r_dvd[N-1:0];
                    end else if (r_pre_ovf || w_q_ovf) begin
                        r_dz_out  <= 1'b0;
                        r_ovf_out <= 1'b1;
                        r_quot    <= r_sign_q ? c_QMIN : c_QMAX;
                        r_remd    <= '0;
                    end else begin
                        r_dz_out  <= 1'b0;
                        r_ovf_out <= 1'b0;
                        r_quot    <= r_sign_q ? -r_low : r_low;
                        r_remd    <= r_sign_r ? -r_rem[N-1:0] : r_rem[N-1:0];
                    end
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == c_IDLE);
    assign bus.out_valid   = (r_state == c_DONE);
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remd;
    assign bus.div_by_zero = r_dz_out;
    assign bus.overflow    = r_ovf_out;
endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_signed_divider
//  Description : Randomized and directed checks of seq_signed_divider against
//                a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_signed_divider;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seq_signed_divider_if #(.N(N)) bus ();

    seq_signed_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Truncating division on 64-bit integers, then range/zero classification
    function automatic void model(input logic [31:0] dvd, input logic [15:0] dvs,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ovf);
        longint a;
        longint b;
        longint lq;
        longint lr;
        a = longint'($signed(dvd));
        b = longint'($signed(dvs));
        dz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            dz = 1'b1;
            q  = 16'hFFFF;
            r  = dvd[15:0];
        end else begin
            lq = a / b;
            lr = a % b;
            if (lq > 32767 || lq < -32768) begin
                ovf = 1'b1;
                q   = ((a < 0) != (b < 0)) ? 16'h8000 : 16'h7FFF;
                r   = 16'h0000;
            end else begin
                q = 16'(lq);
                r = 16'(lr);
            end
        end
    endfunction

    task automatic do_op(input logic [31:0] dvd, input logic [15:0] dvs, input int hold,
                         input string tag, output logic [15:0] gq, output logic [15:0] gr,
                         output logic gdz, output logic govf);
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eovf;
        int          lat;
        model(dvd, dvs, eq, er, edz, eovf);
        @(negedge clk);
        chk({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd18);
        gq   = bus.quotient;
        gr   = bus.remainder;
        gdz  = bus.div_by_zero;
        govf = bus.overflow;
        chk({tag, " quotient"},  64'(gq),   64'(eq));
        chk({tag, " remainder"}, 64'(gr),   64'(er));
        chk({tag, " dz"},        64'(gdz),  64'(edz));
        chk({tag, " ovf"},       64'(govf), 64'(eovf));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.dividend = $urandom;
            bus.divisor  = 16'($urandom);
            @(posedge clk);
            #1;
            chk({tag, " hold valid"},    64'(bus.out_valid), 64'd1);
            chk({tag, " hold in_ready"}, 64'(bus.in_ready),  64'd0);
            chk({tag, " hold quotient"}, 64'(bus.quotient),  64'(eq));
            chk({tag, " hold rem"},      64'(bus.remainder), 64'(er));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " post valid"},    64'(bus.out_valid), 64'd0);
        chk({tag, " post in_ready"}, 64'(bus.in_ready),  64'd1);
        chk({tag, " post busy"},     64'(bus.busy),      64'd0);
    endtask

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
        string       name;
    } dir_t;

    dir_t dir_tab [9];

    initial begin
        logic [15:0] gq;
        logic [15:0] gr;
        logic        gdz;
        logic        govf;
        logic [31:0] d;
        logic [15:0] s;
        int          mode;

        dir_tab[0] = '{32'd1000,       16'd7,      16'h008E, 16'h0006, 1'b0, 1'b0, "1000/7"};
        dir_tab[1] = '{32'hFFFFFC18,   16'd7,      16'hFF72, 16'hFFFA, 1'b0, 1'b0, "-1000/7"};
        dir_tab[2] = '{32'd1000,       16'hFFF9,   16'hFF72, 16'h0006, 1'b0, 1'b0, "1000/-7"};
        dir_tab[3] = '{32'hFFFF8000,   16'd1,      16'h8000, 16'h0000, 1'b0, 1'b0, "-32768/1"};
        dir_tab[4] = '{32'h00008000,   16'd1,      16'h7FFF, 16'h0000, 1'b0, 1'b1, "32768/1"};
        dir_tab[5] = '{32'h00010000,   16'd1,      16'h7FFF, 16'h0000, 1'b0, 1'b1, "0x10000/1"};
        dir_tab[6] = '{32'h80000000,   16'hFFFF,   16'h7FFF, 16'h0000, 1'b0, 1'b1, "min/-1"};
        dir_tab[7] = '{32'd12345,      16'd0,      16'hFFFF, 16'h3039, 1'b1, 1'b0, "12345/0"};
        dir_tab[8] = '{32'd100,        16'd3,      16'h0021, 16'h0001, 1'b0, 1'b0, "100/3"};

        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready",  64'(bus.in_ready),    64'd1);
        chk("reset out_valid", 64'(bus.out_valid),   64'd0);
        chk("reset busy",      64'(bus.busy),        64'd0);
        chk("reset quotient",  64'(bus.quotient),    64'd0);
        chk("reset remainder", 64'(bus.remainder),   64'd0);
        chk("reset flags",     64'({bus.div_by_zero, bus.overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(dir_tab[i].dvd, dir_tab[i].dvs, (i == 0) ? 10 : 0, dir_tab[i].name,
                  gq, gr, gdz, govf);
            chk({dir_tab[i].name, " lit q"},   64'(gq),   64'(dir_tab[i].q));
            chk({dir_tab[i].name, " lit r"},   64'(gr),   64'(dir_tab[i].r));
            chk({dir_tab[i].name, " lit dz"},  64'(gdz),  64'(dir_tab[i].dz));
            chk({dir_tab[i].name, " lit ovf"}, 64'(govf), 64'(dir_tab[i].ovf));
        end

        // Pulses ignored during backpressure must not have started an operation
        @(posedge clk);
        #1;
        chk("idle after hold busy", 64'(bus.busy), 64'd0);

        // Abandon an operation while ITER is on count 5
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 16'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst busy",      64'(bus.busy),      64'd0);
        chk("midrst quotient",  64'(bus.quotient),  64'd0);
        chk("midrst remainder", 64'(bus.remainder), 64'd0);
        chk("midrst flags",     64'({bus.div_by_zero, bus.overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op(32'd100, 16'd3, 0, "post-reset 100/3", gq, gr, gdz, govf);
        chk("post-reset lit q", 64'(gq), 64'h0021);
        chk("post-reset lit r", 64'(gr), 64'h0001);

        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 3);
            d = $urandom;
            s = 16'($urandom);
            case (mode)
                0: ;
                1: d = {{16{d[15]}}, d[15:0]};
                2: d = 32'($signed(d) >>> $urandom_range(0, 31));
                default: begin
                    case ($urandom_range(0, 3))
                        0: s = 16'h0000;
                        1: s = 16'h0001;
                        2: s = 16'hFFFF;
                        default: s = 16'($signed(s) >>> $urandom_range(0, 15));
                    endcase
                    d = 32'($signed(d) >>> $urandom_range(0, 31));
                end
            endcase
            do_op(d, s, 0, $sformatf("rnd%0d %h/%h", i, d, s), gq, gr, gdz, govf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
